seg7_code_capture: RTL and testbench

Receiving end of the 7-segment character path: accepts active-low segment patterns one per handshake, maps each back to the 3-bit character code that drives the HEX decoders, and packs NCHAR characters into one code word for downstream logic. Unrecognized patterns are flagged per character and counted. Used for display loop-back checking and for recovering message words from segment streams.

---
 rtl/seg7_pkg.sv | 50 +++++
 rtl/seg7_code_capture_if.sv | 25 ++
 rtl/seg7_pattern_to_code.sv | 19 +
 rtl/seg7_code_capture.sv | 96 +++++++++
 tb/tb_seg7_code_capture.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low pattern constants, character codes,
// the pattern-to-code map and the capture FSM state type.
package seg7_pkg;

  // Active-low segment patterns (bits [6:0]) for each displayable character.
  localparam logic [6:0] PAT_C0    = 7'h48;
  localparam logic [6:0] PAT_C1    = 7'h30;
  localparam logic [6:0] PAT_C2    = 7'h71;
  localparam logic [6:0] PAT_C3    = 7'h01;
  localparam logic [6:0] PAT_BLANK = 7'h7F;

  // Character codes as used by the HEX decoders.
  localparam logic [2:0] CODE_C0    = 3'b000;
  localparam logic [2:0] CODE_C1    = 3'b001;
  localparam logic [2:0] CODE_C2    = 3'b010;
  localparam logic [2:0] CODE_C3    = 3'b011;
  localparam logic [2:0] CODE_BLANK = 3'b100;
  localparam logic [2:0] CODE_BAD   = 3'b111;

  // Capture sequencing: collect characters, then hold the word for downstream.
  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } cap_state_t;

  // Result of a pattern lookup.
  typedef struct packed {
    logic       bad;
    logic [2:0] code;
  } pat_map_t;

  // Single definition of the pattern map; decoders use the inverse of this.
  function automatic pat_map_t pat_to_code(input logic [6:0] pat);
    pat_map_t r;
    r.bad = 1'b0;
    case (pat)
      PAT_C0:    r.code = CODE_C0;
      PAT_C1:    r.code = CODE_C1;
      PAT_C2:    r.code = CODE_C2;
      PAT_C3:    r.code = CODE_C3;
      PAT_BLANK: r.code = CODE_BLANK;
      default: begin
        r.code = CODE_BAD;
        r.bad  = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_code_capture_if.sv
// Segment-stream in / packed code word out bundle for seg7_code_capture.
interface seg7_code_capture_if #(
  parameter int NCHAR = 4
);
  logic [7:0]         seg_in;
  logic               seg_valid;
  logic               seg_ready;
  logic [3*NCHAR-1:0] code_out;
  logic [NCHAR-1:0]   err_out;
  logic               word_valid;
  logic               word_ready;
  logic [7:0]         err_count;

  // Producer of segment patterns and consumer of words.
  modport master (
    output seg_in, seg_valid, word_ready,
    input  seg_ready, code_out, err_out, word_valid, err_count
  );

  // The capture block itself.
  modport slave (
    input  seg_in, seg_valid, word_ready,
    output seg_ready, code_out, err_out, word_valid, err_count
  );
endinterface

// File: rtl/seg7_pattern_to_code.sv
// Combinational map from one active-low segment pattern to its character code.
module seg7_pattern_to_code
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [2:0] code_o,
  output logic       bad_o
);

  pat_map_t map;

  // Lookup through the shared package map.
  always_comb begin
    map    = pat_to_code(pat_i);
    code_o = map.code;
    bad_o  = map.bad;
  end

endmodule

// File: rtl/seg7_code_capture.sv
// Captures NCHAR segment patterns into one packed code word, first character
// in the top slot, with per-slot bad flags and a saturating bad-pattern count.
module seg7_code_capture
  import seg7_pkg::*;
#(
  parameter int NCHAR = 4
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  seg7_code_capture_if.slave bus
);

  localparam int         IW   = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHAR - 1);

  cap_state_t         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [3*NCHAR-1:0] code_q, code_d;
  logic [NCHAR-1:0]   err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [2:0] pat_code;
  logic       pat_bad;
  logic       accept;
  logic       unused_seg_bit7;

  // Bit 7 (decimal point) carries no character information.
  assign unused_seg_bit7 = bus.seg_in[7];

  seg7_pattern_to_code u_map (
    .pat_i  (bus.seg_in[6:0]),
    .code_o (pat_code),
    .bad_o  (pat_bad)
  );

  assign accept = bus.seg_valid && (state_q == FILL);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q <= FILL;
      idx_q   <= '0;
      code_q  <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: shift characters in during FILL, hold the word during SEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    code_d  = code_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          code_d = {code_q[3*NCHAR-4:0], pat_code};
          err_d  = {err_q[NCHAR-2:0], pat_bad};
          if (pat_bad && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
          end
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = SEND;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.word_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake outputs follow the state directly; data outputs are registers.
  always_comb begin
    bus.seg_ready  = (state_q == FILL);
    bus.word_valid = (state_q == SEND);
    bus.code_out   = code_q;
    bus.err_out    = err_q;
    bus.err_count  = cnt_q;
  end

endmodule

// File: tb/tb_seg7_code_capture.sv
// Directed bench for seg7_code_capture: table of words plus hand-written
// stall, reset and saturation sequences.
module tb_seg7_code_capture;

  localparam int NCHAR = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seg7_code_capture_if #(.NCHAR(NCHAR)) bus ();

  seg7_code_capture #(.NCHAR(NCHAR)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  seg [4];
    logic [11:0] exp_code;
    logic [3:0]  exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic put(input logic [7:0] pat);
    bit done;
    done = 1'b0;
    bus.seg_valid = 1'b1;
    bus.seg_in    = pat;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.seg_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL put_timeout: seg_ready never 1 for pattern %0h", pat);
    end
  endtask

  initial begin
    logic [11:0] held;
    checks   = 0;
    failures = 0;

    vecs[0].seg = '{8'h48, 8'h30, 8'h71, 8'h01};
    vecs[0].exp_code = 12'b000_001_010_011; vecs[0].exp_err = 4'b0000; vecs[0].exp_cnt = 8'd0;
    vecs[1].seg = '{8'hFF, 8'h7F, 8'hFF, 8'h7F};
    vecs[1].exp_code = 12'h924;             vecs[1].exp_err = 4'b0000; vecs[1].exp_cnt = 8'd0;
    vecs[2].seg = '{8'h48, 8'h00, 8'h01, 8'h55};
    vecs[2].exp_code = 12'b000_111_011_111; vecs[2].exp_err = 4'b0101; vecs[2].exp_cnt = 8'd2;
    vecs[3].seg = '{8'h30, 8'hB0, 8'h01, 8'h7F};
    vecs[3].exp_code = 12'b001_001_011_100; vecs[3].exp_err = 4'b0000; vecs[3].exp_cnt = 8'd2;
    vecs[4].seg = '{8'h71, 8'h7F, 8'h08, 8'h48};
    vecs[4].exp_code = 12'b010_100_111_000; vecs[4].exp_err = 4'b0010; vecs[4].exp_cnt = 8'd3;

    bus.seg_in     = 8'h00;
    bus.seg_valid  = 1'b0;
    bus.word_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_seg_ready", {31'd0, bus.seg_ready}, 32'd1);
    chk("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_code", {20'd0, bus.code_out}, 32'd0);
    chk("rst_err", {28'd0, bus.err_out}, 32'd0);
    chk("rst_cnt", {24'd0, bus.err_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table of words, word_ready held high throughout.
    bus.word_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 3) chk($sformatf("w%0d_wv_before_last", v), {31'd0, bus.word_valid}, 32'd0);
        put(vecs[v].seg[c]);
      end
      bus.seg_valid = 1'b0;
      chk($sformatf("w%0d_word_valid", v), {31'd0, bus.word_valid}, 32'd1);
      chk($sformatf("w%0d_seg_ready", v), {31'd0, bus.seg_ready}, 32'd0);
      chk($sformatf("w%0d_code", v), {20'd0, bus.code_out}, {20'd0, vecs[v].exp_code});
      chk($sformatf("w%0d_err", v), {28'd0, bus.err_out}, {28'd0, vecs[v].exp_err});
      chk($sformatf("w%0d_cnt", v), {24'd0, bus.err_count}, {24'd0, vecs[v].exp_cnt});
      @(negedge clk);
      chk($sformatf("w%0d_wv_after_hs", v), {31'd0, bus.word_valid}, 32'd0);
      chk($sformatf("w%0d_code_kept", v), {20'd0, bus.code_out}, {20'd0, vecs[v].exp_code});
      $display("word %0d: code=%03h err=%b cnt=%0d", v, bus.code_out, bus.err_out, bus.err_count);
    end

    // Stall: word_ready low for 10 cycles with seg_valid held high.
    bus.word_ready = 1'b0;
    put(8'h01); put(8'h01); put(8'h30); put(8'h48);
    held = 12'b011_011_001_000;
    bus.seg_in = 8'h00;
    for (int i = 0; i < 10; i++) begin
      chk("stall_seg_ready", {31'd0, bus.seg_ready}, 32'd0);
      chk("stall_code", {20'd0, bus.code_out}, {20'd0, held});
      @(negedge clk);
    end
    chk("stall_cnt", {24'd0, bus.err_count}, 32'd3);
    bus.word_ready = 1'b1;
    put(8'h71); put(8'h71); put(8'h7F); put(8'h30);
    bus.seg_valid = 1'b0;
    chk("post_stall_code", {20'd0, bus.code_out}, {20'd0, 12'b010_010_100_001});
    chk("post_stall_wv", {31'd0, bus.word_valid}, 32'd1);
    $display("stall word: code=%03h", bus.code_out);
    @(negedge clk);

    // Reset after two characters of a word.
    bus.word_ready = 1'b0;
    put(8'h00); put(8'h30);
    bus.seg_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_code", {20'd0, bus.code_out}, 32'd0);
    chk("midrst_err", {28'd0, bus.err_out}, 32'd0);
    chk("midrst_cnt", {24'd0, bus.err_count}, 32'd0);
    chk("midrst_wv", {31'd0, bus.word_valid}, 32'd0);
    chk("midrst_ready", {31'd0, bus.seg_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    put(8'h01); put(8'h01); put(8'h01);
    bus.seg_valid = 1'b0;
    chk("postrst_wv_early", {31'd0, bus.word_valid}, 32'd0);
    put(8'h01);
    bus.seg_valid = 1'b0;
    chk("postrst_wv", {31'd0, bus.word_valid}, 32'd1);
    chk("postrst_code", {20'd0, bus.code_out}, {20'd0, 12'h6DB});
    chk("postrst_err", {28'd0, bus.err_out}, 32'd0);
    $display("post-reset word: code=%03h err=%b", bus.code_out, bus.err_out);

    // Saturation of the bad-pattern counter.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.word_ready = 1'b1;
    for (int i = 0; i < 254; i++) put(8'h22);
    bus.seg_valid = 1'b0;
    chk("cnt_254", {24'd0, bus.err_count}, 32'd254);
    for (int i = 0; i < 6; i++) put(8'h22);
    bus.seg_valid = 1'b0;
    chk("cnt_sat", {24'd0, bus.err_count}, 32'd255);
    $display("saturation: err_count=%0d", bus.err_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
